// File: rtl/mem_arbiter.sv
// Instruction/data arbiter in front of one single-port, read-latency-1 memory.
// Define ARB_STARVE_GUARD_EN to bound data-grant streaks while a fetch waits.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;

  state_t state_q, state_d;
  logic   force_i;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  logic [SW-1:0] streak;

  // Counts data wins that happened while a fetch was left waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  streak <= '0;
    else if (i_gnt || !i_req) streak <= '0;
    else if (d_gnt)           streak <= streak + 1'b1;
  end

  assign force_i = i_req && d_req && (streak == SW'(MAX_D_STREAK));
`else
  assign force_i = 1'b0;
`endif

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (d_req && !force_i) d_gnt = 1'b1;
      else if (i_req)        i_gnt = 1'b1;
    end
  end

  assign mem_en    = i_gnt | d_gnt;
  assign mem_addr  = d_gnt ? d_addr : i_addr;
  assign mem_we    = (d_gnt && d_we) ? d_be : '0;
  assign mem_wdata = d_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Owner of the response arriving next cycle; arbitration never stalls on it.
  always_comb begin
    state_d  = IDLE;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    if (d_gnt)      state_d = RESP_D;
    else if (i_gnt) state_d = RESP_I;
    case (state_q)
      RESP_I:  i_rvalid = 1'b1;
      RESP_D:  d_rvalid = 1'b1;
      default: ;
    endcase
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural read-latency-1 memory.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [0:63];

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory: read-before-write, byte-masked writes.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr[7:2]];
      for (int b = 0; b < BW; b++)
        if (mem_we[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr,
                       input logic we, input logic [BW-1:0] be,
                       input logic [AW-1:0] da, input logic [DW-1:0] wd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_be = be; d_addr = da; d_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  ig_cnt, dg_cnt;
    bit  prev_i, exp_i, ld;
    for (int k = 0; k < 64; k++) mem[k] = 32'h0;
    mem[0]         = 32'hCAFE0001;
    mem[32'h10>>2] = 32'h00500093;
    mem[32'h20>>2] = 32'h20202020;
    mem[32'h24>>2] = 32'h24242424;
    mem[32'h40>>2] = 32'h11223344;

    // reset with both requests raised: everything must stay quiet
    rst = 1'b1;
    drive(1'b1, 32'h10, 1'b1, 1'b1, 4'hF, 32'h40, 32'hFFFFFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);

    // fetch in the first cycle after release
    next_cyc();
    rst = 1'b0;
    drive(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("f_i_gnt", i_gnt, 1);
    chk("f_d_gnt", d_gnt, 0);
    chk("f_mem_en", mem_en, 1);
    chk("f_mem_addr", mem_addr, 32'h10);
    chk("f_mem_we", mem_we, 0);
    next_cyc();
    idle();
    @(negedge clk);
    chk("f_i_rvalid", i_rvalid, 1);
    chk("f_i_rdata", i_rdata, 32'h00500093);
    chk("f_d_rvalid", d_rvalid, 0);
    chk("f_idle_mem_en", mem_en, 0);

    // partial store then back-to-back load of the same word
    next_cyc();
    drive(1'b0, '0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hAABBCCDD);
    @(negedge clk);
    chk("st_d_gnt", d_gnt, 1);
    chk("st_mem_we", mem_we, 4'b0011);
    chk("st_mem_addr", mem_addr, 32'h40);
    chk("st_mem_wdata", mem_wdata, 32'hAABBCCDD);
    next_cyc();
    drive(1'b0, '0, 1'b1, 1'b0, 4'hF, 32'h40, '0);
    @(negedge clk);
    chk("st_ack", d_rvalid, 1);
    chk("ld_d_gnt", d_gnt, 1);
    chk("ld_mem_we", mem_we, 0);
    next_cyc();
    idle();
    @(negedge clk);
    chk("ld_d_rvalid", d_rvalid, 1);
    chk("ld_d_rdata", d_rdata, 32'h1122CCDD);

    // store with no byte enables: granted, acked, memory untouched
    next_cyc();
    drive(1'b0, '0, 1'b1, 1'b1, 4'b0000, 32'h40, 32'h55555555);
    @(negedge clk);
    chk("z_d_gnt", d_gnt, 1);
    chk("z_mem_we", mem_we, 0);
    next_cyc();
    drive(1'b0, '0, 1'b1, 1'b0, 4'hF, 32'h40, '0);
    @(negedge clk);
    chk("z_ack", d_rvalid, 1);
    next_cyc();
    idle();
    @(negedge clk);
    chk("z_rdata", d_rdata, 32'h1122CCDD);

    // both ports requesting for ten cycles
    next_cyc();
    ig_cnt = 0; dg_cnt = 0; prev_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h40, '0);
      exp_i = GUARD && (k % 5 == 4);
      @(negedge clk);
      chk($sformatf("arb%0d_i_gnt", k), i_gnt, exp_i);
      chk($sformatf("arb%0d_d_gnt", k), d_gnt, !exp_i);
      chk($sformatf("arb%0d_addr", k), mem_addr, exp_i ? 32'h10 : 32'h40);
      if (k > 0) chk($sformatf("arb%0d_rv", k), {i_rvalid, d_rvalid}, prev_i ? 2'b10 : 2'b01);
      ig_cnt += int'(i_gnt);
      dg_cnt += int'(d_gnt);
      prev_i = exp_i;
      next_cyc();
    end
    idle();
    @(negedge clk);
    chk("arb_last_rv", {i_rvalid, d_rvalid}, prev_i ? 2'b10 : 2'b01);
    chk("arb_i_cnt", ig_cnt, GUARD ? 2 : 0);
    chk("arb_d_cnt", dg_cnt, GUARD ? 8 : 10);

    // alternating load 0x20 / fetch 0x24, one access per cycle
    next_cyc();
    for (int k = 0; k < 6; k++) begin
      ld = (k % 2 == 0);
      if (ld) drive(1'b0, '0, 1'b1, 1'b0, 4'hF, 32'h20, '0);
      else    drive(1'b1, 32'h24, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      chk($sformatf("alt%0d_en", k), mem_en, 1);
      chk($sformatf("alt%0d_gnt", k), {i_gnt, d_gnt}, ld ? 2'b01 : 2'b10);
      if (k > 0) begin
        chk($sformatf("alt%0d_rv", k), {i_rvalid, d_rvalid}, ld ? 2'b10 : 2'b01);
        chk($sformatf("alt%0d_rd", k), ld ? i_rdata : d_rdata, ld ? 32'h24242424 : 32'h20202020);
      end
      next_cyc();
    end
    idle();
    @(negedge clk);
    chk("alt_last_rv", {i_rvalid, d_rvalid}, 2'b10);
    chk("alt_last_rd", i_rdata, 32'h24242424);

    // reset pulsed while a fetch response is due
    next_cyc();
    drive(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("mr_i_gnt", i_gnt, 1);
    next_cyc();
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_rv_in_rst", i_rvalid, 0);
    next_cyc();
    rst = 1'b0;
    drive(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("mr_rv_after", {i_rvalid, d_rvalid}, 2'b00);
    chk("mr_i_gnt2", i_gnt, 1);
    next_cyc();
    idle();
    @(negedge clk);
    chk("mr_fetch_rv", i_rvalid, 1);
    chk("mr_fetch_rd", i_rdata, 32'hCAFE0001);
    next_cyc();
    @(negedge clk);
    chk("mr_quiet", {i_rvalid, d_rvalid}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width, with the byte-enable width fixed at DATA_W/8.
REQ-003 The block SHALL have parameter MAX_D_STREAK, default 4, meaning the maximum number of consecutive data grants while an instruction request waits (used only under REQ-025).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
REQ-005 The block SHALL have these instruction-port signals:
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_W  fetch data
REQ-006 The block SHALL have these data-port signals:
- d_req  in  1  load/store request
- d_we  in  1  store when 1
- d_be  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  accepted
- d_rvalid  out  1  response valid
- d_rdata  out  DATA_W  load data
REQ-007 The block SHALL have these memory-side signals:
- mem_en  out  1  access enable
- mem_we  out  DATA_W/8  byte write enables
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid one cycle after mem_en

Function
REQ-008 The block SHALL share one single-port synchronous memory (read latency 1) between the instruction and data ports.
REQ-009 A request SHALL be accepted in the cycle in which its req and gnt are both 1.
- i_gnt and d_gnt SHALL be combinational from the req inputs and the arbitration state.
- i_gnt and d_gnt SHALL be mutually exclusive.
REQ-010 Arbitration SHALL take place every cycle, including cycles in which a response is returning, so back-to-back accesses sustain one access per cycle.
REQ-011 Default priority SHALL be: d_req over i_req; i_req alone granted; neither means mem_en=0.
REQ-012 On a grant, the memory signals SHALL be driven in the same cycle:
- mem_en=1
- mem_addr = address of the granted port
- mem_we = d_be if the data port is granted with d_we=1, else all-zero
- mem_wdata = d_wdata
REQ-013 A registered owner FSM SHALL have three states:
- IDLE: no response due.
- RESP_I: instruction response due.
- RESP_D: data response due.
- Next state = RESP_D if d_gnt, else RESP_I if i_gnt, else IDLE.
REQ-014 In RESP_I, i_rvalid SHALL be 1 and i_rdata SHALL equal mem_rdata; otherwise i_rvalid SHALL be 0.
REQ-015 In RESP_D, d_rvalid SHALL be 1 and d_rdata SHALL equal mem_rdata; otherwise d_rvalid SHALL be 0.
REQ-016 A store SHALL also produce a one-cycle d_rvalid acknowledge; d_rdata is don't-care on a store acknowledge.
REQ-017 Requesters SHALL hold req and payload stable until granted; the block SHALL NOT latch ungranted requests.
REQ-018 Each accepted request SHALL produce exactly one rvalid pulse, returned in request order per port.
REQ-019 With d_we=1 and d_be=0, the access SHALL still be granted and acknowledged, with mem_we all-zero.
REQ-020 Simultaneous i_req and d_req SHALL produce exactly one grant per cycle; the loser SHALL see gnt=0 and retry.

Reset
REQ-021 While rst=1, the outputs SHALL be: i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we = 0; FSM = IDLE; streak counter = 0.
REQ-022 rst asserted mid-operation SHALL drop any pending response, with no rvalid pulse after reset release.
REQ-023 Grants SHALL be permitted in the first cycle after rst deasserts.

Configuration
REQ-024 Macro ARB_STARVE_GUARD_EN SHALL select the starvation guard.
REQ-025 With ARB_STARVE_GUARD_EN defined:
- A counter SHALL increment on each d_gnt while i_req=1, and clear on i_gnt or when i_req=0.
- When the counter equals MAX_D_STREAK and both requests are present, i_gnt SHALL be given instead of d_gnt.
REQ-026 Without ARB_STARVE_GUARD_EN, strict data priority SHALL apply, and no counter logic SHALL exist.

Verification
REQ-027 i_req=1, i_addr=0x10, memory[0x10]=0x00500093 -> i_gnt same cycle; next cycle i_rvalid=1, i_rdata=0x00500093.
REQ-028 d_req=1, d_we=1, d_be=0b0011, d_addr=0x40, d_wdata=0xAABBCCDD, old word 0x11223344 -> next cycle d_rvalid=1; a following load from 0x40 returns 0x1122CCDD.
REQ-029 i_req and d_req held together for 10 cycles -> without the macro, 10 d_gnt and 0 i_gnt; with the macro (MAX_D_STREAK=4), grant pattern DDDDI DDDDI.
REQ-030 Alternating load 0x20 / fetch 0x24 every cycle -> one mem_en per cycle, rvalid on the correct port each following cycle, no bubbles.
REQ-031 rst pulsed in the cycle after a fetch grant -> i_rvalid stays 0; after release, a fetch to 0x0 completes normally.
REQ-032 d_req=1, d_we=1, d_be=0 -> d_gnt=1, mem_we=0, d_rvalid pulse, memory unchanged.
